// File: rtl/greyscale_pipe.sv
// RGB -> grey converter: weighted sum (or channel max) through a fixed 3-stage pipeline, with per-frame pixel count.
// Optional binarisation output enabled by defining GREYSCALE_PIPE_THRESHOLD_EN.
module greyscale_pipe #(
   parameter int NUM_ROWS     = 32,
   parameter int NUM_COLS     = 32,
   parameter int NUM_BITS_RGB = 12,
   parameter int OUTPUT_WIDTH = 16,
   parameter int COEF_BITS    = 10,
   parameter int PIPE_LATENCY = 3
) (
   input  logic                                     iclk,
   input  logic                                     irst,
   input  logic [NUM_BITS_RGB-1:0]                  ired_input,
   input  logic [NUM_BITS_RGB-1:0]                  igreen_input,
   input  logic [NUM_BITS_RGB-1:0]                  iblue_input,
   input  logic [$clog2(NUM_ROWS)-1:0]              ix_pos,
   input  logic [$clog2(NUM_COLS)-1:0]              iy_pos,
   input  logic                                     if_val,
   input  logic                                     id_val,
   input  logic [1:0]                               imode,
   input  logic [NUM_BITS_RGB-1:0]                  ithresh,
   output logic [NUM_BITS_RGB-1:0]                  ogrey,
   output logic                                     oGVAL,
   output logic [$clog2(NUM_ROWS)-1:0]              ox_pos,
   output logic [$clog2(NUM_COLS)-1:0]              oy_pos,
   output logic [OUTPUT_WIDTH-1:0]                  odata_out1,
   output logic [OUTPUT_WIDTH-1:0]                  odata_out2,
   output logic                                     obin,
   output logic                                     oframe_done,
   output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]   opix_count
);

   localparam int NB  = NUM_BITS_RGB;
   localparam int XW  = $clog2(NUM_ROWS);
   localparam int YW  = $clog2(NUM_COLS);
   localparam int CW  = $clog2(NUM_ROWS*NUM_COLS+1);
   localparam int W   = NUM_BITS_RGB + COEF_BITS + 2;
   localparam int WTW = COEF_BITS + 1;
   localparam int PW  = 15;
   localparam logic [W-1:0]    ROUND    = W'(1) << (COEF_BITS-1);
   localparam logic [NB+1:0]   GREY_MAX = (NB+2)'((1 << NB) - 1);
   localparam logic [CW-1:0]   MAX_PIX  = CW'(NUM_ROWS*NUM_COLS);

   logic                r_fval_d;
   logic [1:0]          r_mode;
   logic [PIPE_LATENCY-2:0] r_fall;
   logic                w_rise;
   logic                w_fall;
   logic                w_acc;
   logic [1:0]          w_mode;

   logic [WTW-1:0]      w_wr, w_wg, w_wb;
   logic [NB-1:0]       w_max;
   logic [W-1:0]        w_pr, w_pg, w_pb;

   logic                r_v1, r_v2;
   logic [W-1:0]        r_pr, r_pg, r_pb;
   logic [W-1:0]        r_sum;
   logic [XW-1:0]       r_x1, r_x2;
   logic [YW-1:0]       r_y1, r_y2;

   logic [NB+1:0]       w_q;
   logic [NB-1:0]       w_grey;
   logic [PW-1:0]       w_p1, w_p2;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_next;
   logic                w_unused_sum;

   assign w_rise = if_val & ~r_fval_d;
   assign w_fall = ~if_val & r_fval_d;
   assign w_acc  = if_val & id_val;
   // The first pixel of a frame already uses the mode sampled on the rising edge.
   assign w_mode = w_rise ? imode : r_mode;

   always_comb begin
      w_wr = '0;
      w_wg = '0;
      w_wb = '0;
      case (w_mode)
         2'd0: begin
            w_wr = WTW'(306);
            w_wg = WTW'(601);
            w_wb = WTW'(117);
         end
         2'd1: begin
            w_wr = WTW'(341);
            w_wg = WTW'(341);
            w_wb = WTW'(342);
         end
         2'd2: w_wg = WTW'(1) << COEF_BITS;
         default: ;
      endcase
   end

   always_comb begin
      w_max = ired_input;
      if (igreen_input > w_max) w_max = igreen_input;
      if (iblue_input > w_max)  w_max = iblue_input;
   end

   // Max mode rides the same adder tree pre-scaled, so latency stays identical.
   assign w_pr = (w_mode == 2'd3) ? (W'(w_max) << COEF_BITS) : W'(ired_input) * W'(w_wr);
   assign w_pg = (w_mode == 2'd3) ? '0 : W'(igreen_input) * W'(w_wg);
   assign w_pb = (w_mode == 2'd3) ? '0 : W'(iblue_input) * W'(w_wb);

   assign w_q    = r_sum[W-1:COEF_BITS];
   assign w_grey = (w_q > GREY_MAX) ? GREY_MAX[NB-1:0] : w_q[NB-1:0];
   assign w_p1   = {w_grey[NB-1 -: 5], w_grey[NB-1 -: 10]};
   assign w_p2   = {w_grey[NB-6 -: 5], w_grey[NB-1 -: 10]};
   assign w_unused_sum = ^r_sum[COEF_BITS-1:0];

   assign w_cnt_next = (oGVAL && (r_cnt < MAX_PIX)) ? r_cnt + CW'(1) : r_cnt;

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_fval_d <= 1'b0;
         r_mode   <= 2'd0;
         r_fall   <= '0;
      end else begin
         r_fval_d <= if_val;
         r_mode   <= w_mode;
         r_fall   <= (r_fall << 1) | (PIPE_LATENCY-1)'(w_fall);
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_v1  <= 1'b0;
         r_pr  <= '0;
         r_pg  <= '0;
         r_pb  <= '0;
         r_x1  <= '0;
         r_y1  <= '0;
         r_v2  <= 1'b0;
         r_sum <= '0;
         r_x2  <= '0;
         r_y2  <= '0;
      end else begin
         r_v1  <= w_acc;
         r_pr  <= w_pr;
         r_pg  <= w_pg;
         r_pb  <= w_pb;
         r_x1  <= ix_pos;
         r_y1  <= iy_pos;
         r_v2  <= r_v1;
         r_sum <= r_pr + r_pg + r_pb + ROUND;
         r_x2  <= r_x1;
         r_y2  <= r_y1;
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         oGVAL      <= 1'b0;
         ogrey      <= '0;
         odata_out1 <= '0;
         odata_out2 <= '0;
         ox_pos     <= '0;
         oy_pos     <= '0;
      end else begin
         oGVAL <= r_v2;
         if (r_v2) begin
            ogrey      <= w_grey;
            // Packed words are sign-extended from their 15-bit payload.
            odata_out1 <= {{(OUTPUT_WIDTH-PW){w_p1[PW-1]}}, w_p1};
            odata_out2 <= {{(OUTPUT_WIDTH-PW){w_p2[PW-1]}}, w_p2};
            ox_pos     <= r_x2;
            oy_pos     <= r_y2;
         end
      end
   end

   // Frame-end event is delayed so the last pixel's oGVAL is included in the load.
   always_ff @(posedge iclk) begin
      if (irst) begin
         r_cnt       <= '0;
         opix_count  <= '0;
         oframe_done <= 1'b0;
      end else begin
         oframe_done <= r_fall[PIPE_LATENCY-2];
         if (r_fall[PIPE_LATENCY-2]) begin
            opix_count <= w_cnt_next;
            r_cnt      <= '0;
         end else begin
            r_cnt <= w_cnt_next;
         end
      end
   end

`ifdef GREYSCALE_PIPE_THRESHOLD_EN
   logic r_bin;

   always_ff @(posedge iclk) begin
      if (irst)      r_bin <= 1'b0;
      else if (r_v2) r_bin <= (w_grey >= ithresh);
   end

   assign obin = r_bin;
`else
   logic w_unused_thresh;

   assign w_unused_thresh = ^ithresh;
   assign obin = 1'b0;
`endif

endmodule

// File: tb/tb_greyscale_pipe.sv
// Self-checking bench for greyscale_pipe: directed corner frames plus random frames vs. an arithmetic reference model.
module tb_greyscale_pipe;

   localparam int NB     = 12;
   localparam int THRESH = 2048;

   logic          iclk = 1'b0;
   logic          irst;
   logic [NB-1:0] ired_input, igreen_input, iblue_input;
   logic [4:0]    ix_pos, iy_pos;
   logic          if_val, id_val;
   logic [1:0]    imode;
   logic [NB-1:0] ithresh;
   logic [NB-1:0] ogrey;
   logic          oGVAL;
   logic [4:0]    ox_pos, oy_pos;
   logic [15:0]   odata_out1, odata_out2;
   logic          obin, oframe_done;
   logic [10:0]   opix_count;

   greyscale_pipe dut (
      .iclk(iclk), .irst(irst),
      .ired_input(ired_input), .igreen_input(igreen_input), .iblue_input(iblue_input),
      .ix_pos(ix_pos), .iy_pos(iy_pos), .if_val(if_val), .id_val(id_val),
      .imode(imode), .ithresh(ithresh),
      .ogrey(ogrey), .oGVAL(oGVAL), .ox_pos(ox_pos), .oy_pos(oy_pos),
      .odata_out1(odata_out1), .odata_out2(odata_out2),
      .obin(obin), .oframe_done(oframe_done), .opix_count(opix_count)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      bit v;
      int grey;
      int x;
      int y;
      bit bin;
      bit done;
      int cnt;
      int lit;
      int lit_d1;
   } ent_t;

   ent_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   int   m_mode, m_fcnt;
   bit   m_prev_fv;
   int   e_grey, e_d1, e_d2, e_x, e_y, e_cnt;
   bit   e_gval, e_bin, e_done;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic int ref_grey(input int mode, input int r, input int g, input int b);
      int s;
      case (mode)
         0: s = 306*r + 601*g + 117*b;
         1: s = 341*r + 341*g + 342*b;
         2: s = 1024*g;
         default: begin
            s = r;
            if (g > s) s = g;
            if (b > s) s = b;
            s = s * 1024;
         end
      endcase
      s = (s + 512) / 1024;
      return (s > 4095) ? 4095 : s;
   endfunction

   function automatic int ref_pack(input int g, input bit second);
      int hi, lo, p;
      hi = second ? (g / 4) % 32 : (g / 128) % 32;
      lo = (g / 4) % 1024;
      p  = hi * 1024 + lo;
      if (p >= 16384) p = p + 32768;
      return p;
   endfunction

   function automatic int rnd_ch();
      case ($urandom_range(0, 3))
         0: return 0;
         1: return 4095;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   task automatic model_clear();
      q.delete();
      for (int i = 0; i < 2; i++) begin
         ent_t z;
         z.v = 0; z.grey = 0; z.x = 0; z.y = 0; z.bin = 0;
         z.done = 0; z.cnt = 0; z.lit = -1; z.lit_d1 = -1;
         q.push_back(z);
      end
      m_mode = 0; m_fcnt = 0; m_prev_fv = 0;
      e_grey = 0; e_d1 = 0; e_d2 = 0; e_x = 0; e_y = 0; e_cnt = 0;
      e_gval = 0; e_bin = 0; e_done = 0;
   endtask

   task automatic step(input bit fv, input bit dv, input int r, input int g, input int b,
                       input int x, input int y, input int md,
                       input int lit = -1, input int lit_d1 = -1);
      ent_t e;
      e.v = 0; e.grey = 0; e.x = 0; e.y = 0; e.bin = 0;
      e.done = 0; e.cnt = 0; e.lit = lit; e.lit_d1 = lit_d1;
      if_val = fv; id_val = dv;
      ired_input = NB'(r); igreen_input = NB'(g); iblue_input = NB'(b);
      ix_pos = 5'(x); iy_pos = 5'(y); imode = 2'(md);
      if (fv && !m_prev_fv) m_mode = md;
      if (!fv && m_prev_fv) begin
         e.done = 1;
         e.cnt  = m_fcnt;
         m_fcnt = 0;
      end
      if (fv && dv) begin
         e.v    = 1;
         e.grey = ref_grey(m_mode, r, g, b);
         e.x    = x;
         e.y    = y;
`ifdef GREYSCALE_PIPE_THRESHOLD_EN
         e.bin  = (e.grey >= THRESH);
`else
         e.bin  = 0;
`endif
         if (m_fcnt < 1024) m_fcnt++;
      end
      m_prev_fv = fv;
      q.push_back(e);

      @(posedge iclk); #1;

      e = q.pop_front();
      e_gval = e.v;
      if (e.v) begin
         e_grey = e.grey;
         e_d1   = ref_pack(e.grey, 1'b0);
         e_d2   = ref_pack(e.grey, 1'b1);
         e_x    = e.x;
         e_y    = e.y;
         e_bin  = e.bin;
      end
      e_done = e.done;
      if (e.done) e_cnt = e.cnt;

      chk("gval", oGVAL, e_gval);
      chk("grey", ogrey, e_grey);
      chk("data1", odata_out1, e_d1);
      chk("data2", odata_out2, e_d2);
      chk("xpos", ox_pos, e_x);
      chk("ypos", oy_pos, e_y);
      chk("bin", obin, e_bin);
      chk("frame_done", oframe_done, e_done);
      chk("pix_count", opix_count, e_cnt);
      if (e.lit >= 0)    chk("lit_grey", ogrey, e.lit);
      if (e.lit_d1 >= 0) chk("lit_data1", odata_out1, e.lit_d1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      irst = 1'b1;
      @(posedge iclk); #1;
      chk("rst_gval", oGVAL, 0);
      chk("rst_grey", ogrey, 0);
      chk("rst_data1", odata_out1, 0);
      chk("rst_data2", odata_out2, 0);
      chk("rst_xpos", ox_pos, 0);
      chk("rst_ypos", oy_pos, 0);
      chk("rst_bin", obin, 0);
      chk("rst_done", oframe_done, 0);
      chk("rst_count", opix_count, 0);
      irst = 1'b0;
      model_clear();
   endtask

   initial begin
      int acc, len, md, gap;
      bit dv;
      irst = 1'b1;
      if_val = 0; id_val = 0; imode = 0;
      ired_input = 0; igreen_input = 0; iblue_input = 0;
      ix_pos = 0; iy_pos = 0;
      ithresh = NB'(THRESH);
      repeat (2) @(posedge iclk);
      do_reset();
      idle(3);

      // Luma corners and full-scale packing
      step(1, 1, 4095, 4095, 4095, 1, 2, 0, 4095, 65535);
      step(1, 1, 4095, 0, 0, 3, 4, 0, 1224);
      step(1, 1, 0, 4095, 0, 5, 6, 0, 2403);
      step(1, 1, 0, 0, 4095, 7, 8, 0, 468);
      idle(4);

      // Max mode; imode change mid-frame must be ignored
      step(1, 1, 100, 3000, 200, 9, 9, 3, 3000);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 100, 3000, 200, 10, 10, 0, 3000);
      step(1, 1, 50, 20, 4000, 11, 11, 1, 4000);
      idle(4);

      // Threshold boundary via green passthrough
      step(1, 1, 0, 2047, 0, 1, 1, 2, 2047);
      step(1, 1, 4095, 2048, 4095, 2, 2, 2, 2048);
      idle(4);

      // Empty one-cycle frame, then back-to-back frames
      step(1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(1, 1, 10, 20, 30, 3, 3, 1);
      idle(4);

      // 1024 pixels with gaps
      acc = 0;
      for (int i = 0; i < 5000 && acc < 1024; i++) begin
         dv = ($urandom_range(0, 2) != 0);
         step(1, dv, rnd_ch(), rnd_ch(), rnd_ch(), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 0);
         if (dv) acc++;
      end
      idle(5);
      chk("count_1024", opix_count, 1024);

      // Counter saturation
      for (int i = 0; i < 1030; i++)
         step(1, 1, i % 4096, 0, 0, i % 32, 0, 2);
      idle(5);
      chk("count_sat", opix_count, 1024);

      // Reset with two pixels in flight, then frame starting right at release
      step(1, 1, 1000, 2000, 3000, 1, 1, 1);
      step(1, 1, 4000, 100, 200, 2, 2, 1);
      step(1, 1, 300, 600, 900, 3, 3, 1);
      do_reset();
      step(1, 1, 100, 3000, 200, 4, 4, 3, 3000);
      step(1, 1, 700, 10, 20, 5, 5, 0, 700);
      idle(4);
      chk("count_after_rst", opix_count, 2);

      // Random frames
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(1, 40);
         md  = $urandom_range(0, 3);
         for (int i = 0; i < len; i++)
            step(1, ($urandom_range(0, 3) != 0), rnd_ch(), rnd_ch(), rnd_ch(),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 (i == 0) ? md : int'($urandom_range(0, 3)));
         gap = $urandom_range(1, 4);
         idle(gap);
      end
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
